// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset control unit: FSM states,
// ALU codes, opcodes and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    CLS_OTHER,
    CLS_R,
    CLS_I,
    CLS_BRANCH
  } op_class_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  // Only the classes whose ALU operation depends on funct3/funct7 are told apart.
  function automatic op_class_t classify(input logic [6:0] op);
    op_class_t cls;
    case (op)
      OP_RTYPE:  cls = CLS_R;
      OP_ITYPE:  cls = CLS_I;
      OP_BRANCH: cls = CLS_BRANCH;
      default:   cls = CLS_OTHER;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps {opcode class, funct3, funct7b5} to the 3-bit ALU control code and
// flags funct3 values outside the supported subset.
module alu_decoder
  import ctrl_pkg::*;
(
  input  op_class_t  op_class,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_ctrl,
  output logic       illegal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (op_class)
      CLS_BRANCH: begin
        alu_ctrl = ALU_SUB;
        illegal  = (funct3 != 3'b000) && (funct3 != 3'b001);
      end
      CLS_R, CLS_I: begin
        case (funct3)
          // funct7b5 on an I-type is an immediate bit, so only R-type subtracts
          3'b000:  alu_ctrl = (op_class == CLS_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: illegal  = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM for the RV32I-subset core. Define ILLEGAL_TRAP_EN to
// make illegal instructions lock into TRAP; otherwise they retire as NOPs.
module mc_control_fsm
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       alu_nz,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic       reg_we,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] result_src,
  output logic       illegal
);

  state_t     r_state;
  state_t     w_next;
  op_class_t  w_op_class;
  logic [2:0] w_alu_ctrl;
  logic       w_alu_illegal;
  logic       w_opcode_known;
  logic       w_illegal;
  logic       w_take;

  assign w_op_class     = classify(opcode);
  assign w_opcode_known = (opcode == OP_LOAD)   || (opcode == OP_STORE) ||
                          (opcode == OP_RTYPE)  || (opcode == OP_ITYPE) ||
                          (opcode == OP_BRANCH) || (opcode == OP_JAL);
  assign w_illegal      = !w_opcode_known || w_alu_illegal;
  assign w_take         = ((funct3 == 3'b000) && !alu_nz) || ((funct3 == 3'b001) && alu_nz);

  alu_decoder u_alu_decoder (
    .op_class (w_op_class),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .alu_ctrl (w_alu_ctrl),
    .illegal  (w_alu_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_ctrl   = ALU_ADD;
    result_src = RES_ALUOUT;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        if (w_illegal) begin
          illegal = 1'b1;
`ifdef ILLEGAL_TRAP_EN
          w_next  = S_TRAP;
`else
          w_next  = S_FETCH;
`endif
        end else begin
          case (opcode)
            OP_LOAD, OP_STORE: w_next = S_MEM_ADR;
            OP_RTYPE:          w_next = S_EXEC_R;
            OP_ITYPE:          w_next = S_EXEC_I;
            OP_BRANCH:         w_next = S_BRANCH;
            OP_JAL:            w_next = S_JAL;
            default:           w_next = S_FETCH;
          endcase
        end
      end
      S_MEM_ADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        w_next    = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src = RES_MEMDATA;
        reg_we     = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_ctrl  = w_alu_ctrl;
        w_next    = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = w_alu_ctrl;
        w_next    = S_ALU_WB;
      end
      S_ALU_WB: begin
        result_src = RES_ALUOUT;
        reg_we     = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_ctrl   = ALU_SUB;
        result_src = RES_ALUOUT;
        pc_we      = w_take;
        w_next     = S_FETCH;
      end
      S_JAL: begin
        // ALU forms old PC + 4 for the link write in ALU_WB while PC takes the target
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_we      = 1'b1;
        w_next     = S_ALU_WB;
      end
      S_TRAP: begin
        illegal = 1'b1;
        w_next  = S_TRAP;
      end
      default: w_next = S_FETCH;
    endcase

    if (rst) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      reg_we     = 1'b0;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      alu_ctrl   = ALU_ADD;
      result_src = RES_ALUOUT;
      illegal    = 1'b0;
    end
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle control unit for the RV32I-subset core; it is the producer side of the ALU interface.
- Decodes the instruction register and sequences fetch, decode, execute, memory and writeback states.
- Drives the ALU operand selects and the 3-bit ALU control code, and consumes the ALU nonzero flag for branch resolution.
- Controls a shared instruction/data memory port through a req/ready handshake.

Parameters:
none (fixed RV32 subset: add/sub/and/or/slt, addi/andi/ori/slti, lw, sw, beq, bne, jal)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
opcode  in  7  instr[6:0] from instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
alu_nz  in  1  ALU flag: 1 when ALU result nonzero, 0 when zero
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write strobe, valid only with mem_req
iord  out  1  address select: 0=PC, 1=ALU-out register
ir_we  out  1  instruction register load
pc_we  out  1  PC load
reg_we  out  1  register file write
alu_src_a  out  2  00=PC, 01=old PC, 10=rs1 register
alu_src_b  out  2  00=rs2 register, 01=immediate, 10=constant 4
alu_ctrl  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT
result_src  out  2  00=ALU-out register, 01=memory data register, 10=ALU result (direct)
illegal  out  1  unsupported instruction detected

Behaviour:
- Reset: state=FETCH. Every output is 0 in any cycle where rst=1. Reset mid-handshake abandons the request; mem_ready with mem_req=0 is ignored.
- All outputs are decoded combinationally from state and the instruction fields. Unlisted outputs are 0.
- FETCH: mem_req=1, iord=0. Wait while !mem_ready. On mem_ready, in the same cycle: ir_we=1, pc_we=1, src_a=00, src_b=10, ADD, result_src=10 (PC<=PC+4). Next state DECODE.
- DECODE: src_a=01, src_b=01, ADD; the branch/jump target is latched in the ALU-out register. Next state by opcode:
  - 0000011 or 0100011 -> MEM_ADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other opcode -> ILLEGAL handling
- MEM_ADR: src_a=10, src_b=01, ADD. lw -> MEM_RD; sw -> MEM_WR.
- MEM_RD: mem_req=1, iord=1; on mem_ready -> MEM_WB.
- MEM_WB: result_src=01, reg_we=1 -> FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1; on mem_ready -> FETCH.
- EXEC_R: src_a=10, src_b=00, alu_ctrl decoded -> ALU_WB.
- EXEC_I: src_a=10, src_b=01, alu_ctrl decoded -> ALU_WB.
- ALU_WB: result_src=00, reg_we=1 -> FETCH.
- BRANCH: src_a=10, src_b=00, SUB, result_src=00.
  - pc_we=1 iff (funct3=000 and alu_nz=0) or (funct3=001 and alu_nz=1).
  - Next state FETCH.
- JAL: src_a=01, src_b=10, ADD, result_src=00, pc_we=1 (PC<=target). Next state ALU_WB, which writes old PC+4 to rd.
- ALU decode, funct3:
  - 000: ADD; SUB only for R-type with funct7b5=1.
  - 010: SLT.
  - 110: OR.
  - 111: AND.
  - Any other funct3, or a branch funct3 outside {000,001}, is illegal.
- Latency (ready same cycle):
  - R/I-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch: 3 cycles
  - jal: 4 cycles
  - Each memory wait cycle adds 1.

Optional Feature:
- ILLEGAL_TRAP_EN defined: an illegal instruction enters TRAP. TRAP is absorbing until rst and drives illegal=1 with all other outputs 0.
- Undefined: an illegal instruction is a NOP. illegal pulses 1 for the DECODE cycle and the FSM returns to FETCH (PC already +4).

Decomposition:
- Package ctrl_pkg holds:
  - the state enum
  - alu_ctrl codes
  - opcode constants
  - src_a, src_b and result_src select codes
- Sub-module alu_decoder: combinational mapping {opcode class, funct3, funct7b5} -> alu_ctrl plus an illegal flag.

Test Plan:
- Reset: rst=1 for 2 cycles while mem_ready=1 -> all outputs 0. After release, cycle 1 shows mem_req=1, iord=0.
- R-type sub (opcode 0110011, funct3 000, funct7b5 1), fetch ready delayed 2 cycles -> mem_req held 3 cycles; EXEC_R alu_ctrl=001; ALU_WB reg_we=1.
- beq with alu_nz=0 -> BRANCH cycle pc_we=1, alu_ctrl=001. bne with alu_nz=0 -> pc_we=0.
- sw with mem_ready delayed 3 cycles -> mem_req=mem_we=iord=1 for 4 cycles, then FETCH.
- lw -> MEM_WB cycle shows result_src=01, reg_we=1; total 5 cycles with zero-wait memory.
- opcode 1110011:
  - with ILLEGAL_TRAP_EN: illegal stays 1 and mem_req stays 0 until rst.
  - without it: illegal=1 for one cycle, then FETCH.
